// File: rtl/hilihase_event_sched.sv
// hilihase_event_sched
//
// Scheduler between DUT signals and the co-simulation host bridge.
// Watches NUM_SIG one-bit signals for value changes. Each change is
// timestamped against a time-slot counter. Changes leave one at a time
// on a valid/ready event channel, chosen by round-robin. In the other
// direction, host drive commands (id, value) update a bank of drive
// outputs. Ids run from 1 to NUM_SIG; id 0 is reserved.
//
// Ports:
//   clk, rst_n      single clock, asynchronous active-low reset
//   tick            time-slot pulse, advances time_cnt
//   sig_in          monitored signals, bit i has id i+1
//   ev_valid/ready  event handshake
//   ev_id           id of the changed signal
//   ev_val          new value of the signal
//   ev_time         time slot of the change
//   ev_lost         an earlier change of this signal was overwritten
//   drv_valid/ready drive command handshake (ready is 1 after reset)
//   drv_id          drive command target id
//   drv_val         drive command value
//   drv_out         driven values, bit i has id i+1
//   drv_err         one-cycle pulse for an out-of-range drive id
//   time_cnt        current time slot
module hilihase_event_sched #(
    parameter int NUM_SIG = 5,
    parameter int ID_W    = 3,
    parameter int TIME_W  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic [NUM_SIG-1:0] sig_in,
    output logic               ev_valid,
    input  logic               ev_ready,
    output logic [ID_W-1:0]    ev_id,
    output logic               ev_val,
    output logic [TIME_W-1:0]  ev_time,
    output logic               ev_lost,
    input  logic               drv_valid,
    output logic               drv_ready,
    input  logic [ID_W-1:0]    drv_id,
    input  logic               drv_val,
    output logic [NUM_SIG-1:0] drv_out,
    output logic               drv_err,
    output logic [TIME_W-1:0]  time_cnt
);

    localparam int IDX_W = $clog2(NUM_SIG);
    localparam int SUM_W = IDX_W + 1;

    logic [NUM_SIG-1:0] sig_q;
    logic [NUM_SIG-1:0] pending;
    logic [NUM_SIG-1:0] lost;
    logic [NUM_SIG-1:0] snap_val;
    logic [TIME_W-1:0]  snap_time [NUM_SIG];
    logic [IDX_W-1:0]   rr_ptr;

    logic [NUM_SIG-1:0] change;
    logic [NUM_SIG-1:0] rot;
    logic [NUM_SIG-1:0] gnt_vec;
    logic [IDX_W-1:0]   gnt_idx;
    logic [IDX_W-1:0]   rr_next;
    logic [SUM_W-1:0]   idx_sum;
    logic               gnt_found;
    logic               load_en;
    logic               do_grant;
    logic               drv_id_ok;

    assign change    = sig_in ^ sig_q;
    assign load_en   = !ev_valid || ev_ready;
    assign do_grant  = load_en && gnt_found;
    assign drv_id_ok = (drv_id != '0) && (drv_id <= ID_W'(NUM_SIG));

    // Rotate pending so that bit 0 is the rr_ptr position. The first set
    // bit of rot is then the next index in round-robin order.
    assign rot = NUM_SIG'({pending, pending} >> rr_ptr);

    // Find the first set bit of rot. Its offset is then mapped back to an
    // absolute index modulo NUM_SIG.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx_sum   = '0;
        for (int k = 0; k < NUM_SIG; k++) begin
            if (!gnt_found && rot[k]) begin
                gnt_found = 1'b1;
                idx_sum   = {1'b0, rr_ptr} + SUM_W'(k);
                if (idx_sum >= SUM_W'(NUM_SIG)) begin
                    idx_sum = idx_sum - SUM_W'(NUM_SIG);
                end
                gnt_idx = idx_sum[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        gnt_vec = '0;
        for (int i = 0; i < NUM_SIG; i++) begin
            gnt_vec[i] = do_grant && (gnt_idx == IDX_W'(i));
        end
        rr_next = (gnt_idx == IDX_W'(NUM_SIG - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end

    // Change tracking and the event output register. The grant reads the
    // old snapshot. So a change that arrives on the granted index in the
    // same cycle stays pending, with its new snapshot and without a lost
    // flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q    <= '0;
            pending  <= '0;
            lost     <= '0;
            snap_val <= '0;
            rr_ptr   <= '0;
            time_cnt <= '0;
            ev_valid <= 1'b0;
            ev_id    <= '0;
            ev_val   <= 1'b0;
            ev_time  <= '0;
            ev_lost  <= 1'b0;
            for (int i = 0; i < NUM_SIG; i++) begin
                snap_time[i] <= '0;
            end
        end else begin
            sig_q    <= sig_in;
            pending  <= (pending & ~gnt_vec) | change;
            lost     <= (lost | (change & pending)) & ~gnt_vec;
            snap_val <= (snap_val & ~change) | (sig_in & change);
            for (int i = 0; i < NUM_SIG; i++) begin
                if (change[i]) begin
                    snap_time[i] <= time_cnt;
                end
            end
            if (tick) begin
                time_cnt <= time_cnt + TIME_W'(1);
            end
            if (load_en) begin
                ev_valid <= gnt_found;
                if (gnt_found) begin
                    ev_id   <= ID_W'(gnt_idx) + ID_W'(1);
                    ev_val  <= snap_val[gnt_idx];
                    ev_time <= snap_time[gnt_idx];
                    ev_lost <= lost[gnt_idx];
                    rr_ptr  <= rr_next;
                end
            end
        end
    end

    // The drive bank takes a command every cycle. An unknown id leaves
    // drv_out unchanged and pulses drv_err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drv_out   <= '0;
            drv_err   <= 1'b0;
            drv_ready <= 1'b0;
        end else begin
            drv_ready <= 1'b1;
            drv_err   <= drv_valid && !drv_id_ok;
            for (int i = 0; i < NUM_SIG; i++) begin
                if (drv_valid && (drv_id == ID_W'(i + 1))) begin
                    drv_out[i] <= drv_val;
                end
            end
        end
    end

endmodule

// File: tb/tb_hilihase_event_sched.sv
// Directed testbench for hilihase_event_sched.
// It uses NUM_SIG=5, ID_W=3 and TIME_W=4 so that time wrap is reachable.
module tb_hilihase_event_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic [4:0] sig_in;
    logic       ev_valid;
    logic       ev_ready;
    logic [2:0] ev_id;
    logic       ev_val;
    logic [3:0] ev_time;
    logic       ev_lost;
    logic       drv_valid;
    logic       drv_ready;
    logic [2:0] drv_id;
    logic       drv_val;
    logic [4:0] drv_out;
    logic       drv_err;
    logic [3:0] time_cnt;

    int compare_count  = 0;
    int mismatch_count = 0;

    hilihase_event_sched #(
        .NUM_SIG (5),
        .ID_W    (3),
        .TIME_W  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .sig_in    (sig_in),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_id     (ev_id),
        .ev_val    (ev_val),
        .ev_time   (ev_time),
        .ev_lost   (ev_lost),
        .drv_valid (drv_valid),
        .drv_ready (drv_ready),
        .drv_id    (drv_id),
        .drv_val   (drv_val),
        .drv_out   (drv_out),
        .drv_err   (drv_err),
        .time_cnt  (time_cnt)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge and are sampled there too.
    task automatic apply_stimulus(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_event(input string tag, input int id, input int val,
                               input int t, input int lst);
        check_output({tag, "_valid"}, 32'(ev_valid), 32'd1);
        check_output({tag, "_id"},    32'(ev_id),    32'(id));
        check_output({tag, "_val"},   32'(ev_val),   32'(val));
        check_output({tag, "_time"},  32'(ev_time),  32'(t));
        check_output({tag, "_lost"},  32'(ev_lost),  32'(lst));
    endtask

    initial begin
        rst_n     = 1'b0;
        tick      = 1'b0;
        sig_in    = 5'b00101;
        ev_ready  = 1'b1;
        drv_valid = 1'b0;
        drv_id    = 3'd0;
        drv_val   = 1'b0;

        // Reset values, then the initial-value report for ids 1 and 3
        apply_stimulus(2);
        check_output("rst_ev_valid", 32'(ev_valid), 32'd0);
        check_output("rst_drv_ready", 32'(drv_ready), 32'd0);
        check_output("rst_drv_out", 32'(drv_out), 32'd0);
        check_output("rst_time", 32'(time_cnt), 32'd0);
        rst_n = 1'b1;
        apply_stimulus(1);
        check_output("init_empty", 32'(ev_valid), 32'd0);
        check_output("drv_ready_up", 32'(drv_ready), 32'd1);
        apply_stimulus(1);
        check_event("init_id1", 1, 1, 0, 0);
        apply_stimulus(1);
        check_event("init_id3", 3, 1, 0, 0);
        apply_stimulus(1);
        check_output("init_done", 32'(ev_valid), 32'd0);

        // All five toggle together, twice; round robin restarts at id 1
        rst_n  = 1'b0;
        sig_in = 5'b00000;
        apply_stimulus(1);
        rst_n = 1'b1;
        apply_stimulus(1);
        sig_in = 5'b11111;
        apply_stimulus(1);
        for (int k = 1; k <= 5; k++) begin
            apply_stimulus(1);
            check_event($sformatf("rr1_%0d", k), k, 1, 0, 0);
        end
        sig_in = 5'b00000;
        apply_stimulus(1);
        check_output("rr_gap", 32'(ev_valid), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            apply_stimulus(1);
            check_event($sformatf("rr2_%0d", k), k, 0, 0, 0);
        end
        apply_stimulus(1);
        check_output("rr_done", 32'(ev_valid), 32'd0);

        // Stall: id 1 holds the register while id 2 changes 0->1->0
        ev_ready = 1'b0;
        tick     = 1'b1;
        apply_stimulus(3);
        tick = 1'b0;
        check_output("time_3", 32'(time_cnt), 32'd3);
        sig_in = 5'b00001;
        apply_stimulus(2);
        check_event("stall_id1", 1, 1, 3, 0);
        sig_in = 5'b00011;
        apply_stimulus(1);
        tick = 1'b1;
        apply_stimulus(1);
        tick   = 1'b0;
        sig_in = 5'b00001;
        check_output("time_4", 32'(time_cnt), 32'd4);
        apply_stimulus(1);
        check_event("stall_hold", 1, 1, 3, 0);
        ev_ready = 1'b1;
        apply_stimulus(1);
        check_event("stall_id2", 2, 0, 4, 1);
        apply_stimulus(1);
        check_output("stall_done", 32'(ev_valid), 32'd0);

        // Drive commands
        drv_valid = 1'b1;
        drv_id    = 3'd2;
        drv_val   = 1'b1;
        apply_stimulus(1);
        check_output("drv_id2", 32'(drv_out), 32'h02);
        check_output("drv_id2_err", 32'(drv_err), 32'd0);
        drv_id = 3'd5;
        apply_stimulus(1);
        check_output("drv_id5", 32'(drv_out), 32'h12);
        drv_id = 3'd0;
        apply_stimulus(1);
        check_output("drv_id0_err", 32'(drv_err), 32'd1);
        check_output("drv_id0_out", 32'(drv_out), 32'h12);
        drv_id = 3'd6;
        apply_stimulus(1);
        check_output("drv_id6_err", 32'(drv_err), 32'd1);
        check_output("drv_id6_out", 32'(drv_out), 32'h12);
        drv_valid = 1'b0;
        apply_stimulus(1);
        check_output("drv_err_clear", 32'(drv_err), 32'd0);

        // Time wrap: a change in slot 15, then a tick back to 0
        tick = 1'b1;
        apply_stimulus(11);
        tick = 1'b0;
        check_output("time_15", 32'(time_cnt), 32'd15);
        sig_in = 5'b00000;
        apply_stimulus(1);
        tick = 1'b1;
        apply_stimulus(1);
        tick = 1'b0;
        check_event("wrap_ev", 1, 0, 15, 0);
        check_output("time_wrap", 32'(time_cnt), 32'd0);
        apply_stimulus(1);
        check_output("wrap_done", 32'(ev_valid), 32'd0);

        // Reset mid-operation: one event loaded, three still pending
        ev_ready = 1'b0;
        sig_in   = 5'b01111;
        apply_stimulus(2);
        check_event("pre_rst", 2, 1, 0, 0);
        rst_n = 1'b0;
        #1;
        check_output("midrst_valid", 32'(ev_valid), 32'd0);
        check_output("midrst_drv_out", 32'(drv_out), 32'd0);
        sig_in   = 5'b00000;
        ev_ready = 1'b1;
        apply_stimulus(1);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(1);
            check_output($sformatf("post_rst_%0d", k), 32'(ev_valid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
